// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default widths,
// FSM state encoding and the NOP word the memory returns off the end of
// the program.
package instr_fetch_unit_pkg;

  localparam int IFU_ADDR_W = 8;
  localparam int IFU_DATA_W = 32;

  localparam logic [31:0] IFU_NOP = 32'h0000_0000;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } ifu_state_e;

endpackage

// File: rtl/instr_fetch_unit_skid_buf.sv
// ifetch_skid_buf: two-entry in-order FIFO between instruction capture and
// the decode-facing outputs. Entry 0 is always the head, so the outputs come
// straight from storage registers. A flush empties both entries at once.
// Only used when IFETCH_SKID_EN is defined.
module ifetch_skid_buf
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = IFU_ADDR_W,
  parameter int DATA_W = IFU_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              pop,
  output logic              full,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_valid
);

  localparam logic [DATA_W-1:0] NOP_C = DATA_W'(IFU_NOP);

  logic [DATA_W-1:0] data0_r;
  logic [DATA_W-1:0] data1_r;
  logic [ADDR_W-1:0] pc0_r;
  logic [ADDR_W-1:0] pc1_r;
  logic [1:0]        count_r;
  logic              pop_s;
  logic              push_s;

  // Qualify pop/push against occupancy so the count can never under/overflow.
  always_comb begin
    pop_s  = pop && (count_r != 2'd0);
    push_s = push && ((count_r != 2'd2) || pop_s);
  end

  // Storage and occupancy; entry 1 shifts down into entry 0 on a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data0_r <= NOP_C;
      data1_r <= NOP_C;
      pc0_r   <= {ADDR_W{1'b0}};
      pc1_r   <= {ADDR_W{1'b0}};
      count_r <= 2'd0;
    end else if (flush) begin
      count_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            data0_r <= push_data;
            pc0_r   <= push_pc;
          end else begin
            data1_r <= push_data;
            pc1_r   <= push_pc;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          data0_r <= data1_r;
          pc0_r   <= pc1_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            data0_r <= push_data;
            pc0_r   <= push_pc;
          end else begin
            data0_r <= data1_r;
            pc0_r   <= pc1_r;
            data1_r <= push_data;
            pc1_r   <= push_pc;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign full      = (count_r == 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign out_data  = data0_r;
  assign out_pc    = pc0_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, addresses the combinational instruction
// memory, registers each fetched word and hands it to decode over a
// valid/ready handshake. Supports redirect with flush, backpressure stall
// and a HALT state entered after LAST_PC is issued.
// Build option IFETCH_SKID_EN: inserts a 2-entry skid buffer so fetch runs
// one extra cycle after instr_ready drops instead of stalling at once.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W   = IFU_ADDR_W,
  parameter int DATA_W   = IFU_DATA_W,
  parameter int RESET_PC = 0,
  parameter int LAST_PC  = 6
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] RESET_PC_C = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] LAST_PC_C  = ADDR_W'(LAST_PC);

  ifu_state_e        state_r;
  logic [ADDR_W-1:0] pc_r;
  logic              halted_r;
  logic              slot_free_s;
  logic              capture_s;

  assign imem_addr = pc_r;
  assign halted    = halted_r;

  // A word is captured only while fetching into a free slot and no redirect is pending.
  always_comb begin
    capture_s = 1'b0;
    if ((state_r == ST_FETCH) && slot_free_s && !redirect) begin
      capture_s = 1'b1;
    end else begin
      capture_s = 1'b0;
    end
  end

  // PC / state machine: redirect beats everything, then fetch advances or halts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_FETCH;
      pc_r     <= RESET_PC_C;
      halted_r <= 1'b0;
    end else if (redirect) begin
      state_r  <= ST_FETCH;
      pc_r     <= redirect_pc;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (capture_s) begin
            if (pc_r == LAST_PC_C) begin
              state_r  <= ST_HALT;
              halted_r <= 1'b1;
            end else begin
              pc_r <= pc_r + ADDR_W'(1);
            end
          end
        end
        ST_HALT: begin
          state_r <= ST_HALT;
        end
        default: begin
          state_r <= ST_FETCH;
        end
      endcase
    end
  end

`ifdef IFETCH_SKID_EN
  logic buf_full_s;

  assign slot_free_s = !buf_full_s;

  ifetch_skid_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (capture_s),
    .push_data (imem_rdata),
    .push_pc   (pc_r),
    .pop       (instr_ready),
    .full      (buf_full_s),
    .out_data  (instr),
    .out_pc    (instr_pc),
    .out_valid (instr_valid)
  );
`else
  localparam logic [DATA_W-1:0] NOP_C = DATA_W'(IFU_NOP);

  logic [DATA_W-1:0] instr_r;
  logic [ADDR_W-1:0] instr_pc_r;
  logic              valid_r;
  logic              xfer_s;

  // The single output slot frees up when empty or being handed to decode.
  always_comb begin
    xfer_s      = valid_r && instr_ready;
    slot_free_s = !valid_r || xfer_s;
  end

  // Output register: flush on redirect, load on capture, clear after last transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_r    <= NOP_C;
      instr_pc_r <= {ADDR_W{1'b0}};
      valid_r    <= 1'b0;
    end else if (redirect) begin
      valid_r <= 1'b0;
    end else if (capture_s) begin
      instr_r    <= imem_rdata;
      instr_pc_r <= pc_r;
      valid_r    <= 1'b1;
    end else if (xfer_s) begin
      valid_r <= 1'b0;
    end
  end

  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;
  assign instr_valid = valid_r;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected (pc, word) pairs are queued
// when a fetch stream is started and checked as decode accepts each word.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        halted;

  logic [31:0] mem [0:255];

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   xfer_cyc [0:255];
  bit   mon_en = 1'b0;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted)
  );

  assign imem_rdata = mem[imem_addr];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int p = lo; p <= hi; p++) begin
      sb.push_back({8'(p), mem[p]});
    end
  endtask

  task automatic drain(input string tag, input int max_cyc);
    bit done;
    done = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !instr_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_addr_valid(input string tag, input logic [7:0] a, input bit use_pc);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (instr_valid && (use_pc ? (instr_pc == a) : (imem_addr == a))) begin
        hit = 1'b1;
        break;
      end
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  // Scoreboard monitor: every accepted word must match the queue head.
  always @(negedge clk) begin
    if (!rst && mon_en && instr_valid && instr_ready && !redirect) begin
      if (sb.size() == 0) begin
        chk("spurious_xfer", 32'(instr_pc), 32'hFFFF_FFFF);
      end else begin
        chk("xfer_pc", 32'(instr_pc), 32'(sb[0].pc));
        chk("xfer_instr", instr, sb[0].data);
        if (instr_pc == 8'd6) chk("halted_at_last", 32'(halted), 32'd1);
        xfer_cyc[instr_pc] <= cyc;
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
    mem[0] = 32'h2001_0003;
    mem[1] = 32'h2002_0009;
    mem[2] = 32'h0022_1820;
    mem[3] = 32'hAC03_0004;
    mem[4] = 32'h8C04_0004;
    mem[5] = 32'h1064_0001;
    mem[6] = 32'h0041_3820;
    for (int i = 0; i < 256; i++) xfer_cyc[i] = 0;

    rst         = 1'b1;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'd0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);

    // Phase 1: free-running program 0..6 then halt
    @(negedge clk);
    rst = 1'b0;
    push_range(0, 6);
    instr_ready = 1'b1;
    mon_en = 1'b1;
    drain("p1_drain", 40);
    chk("p1_halted", 32'(halted), 32'd1);
    chk("p1_valid_drop", 32'(instr_valid), 32'd0);
    chk("p1_pc_hold", 32'(imem_addr), 32'd6);
    chk("p1_b2b", 32'(xfer_cyc[6] - xfer_cyc[0]), 32'd6);

    // Phase 2: back-to-back redirects out of HALT (last wins), then stall at pc 2
    @(posedge clk); #1;
    redirect = 1'b1;
    redirect_pc = 8'd5;
    @(posedge clk); #1;
    redirect_pc = 8'd0;
    sb.delete();
    push_range(0, 6);
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("p2_halt_clr", 32'(halted), 32'd0);
    chk("p2_flush", 32'(instr_valid), 32'd0);
    chk("p2_last_wins", 32'(imem_addr), 32'd0);
    wait_addr_valid("p2_reach_pc2", 8'd2, 1'b1);
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_pc", 32'(instr_pc), 32'd2);
      chk("stall_instr", instr, mem[2]);
`ifdef IFETCH_SKID_EN
      chk("stall_addr", 32'(imem_addr), (k == 0) ? 32'd3 : 32'd4);
`else
      chk("stall_addr", 32'(imem_addr), 32'd3);
`endif
    end
    @(posedge clk); #1;
    instr_ready = 1'b1;
    drain("p2_drain", 40);
    chk("p2_b2b_23", 32'(xfer_cyc[3] - xfer_cyc[2]), 32'd1);
    chk("p2_b2b_34", 32'(xfer_cyc[4] - xfer_cyc[3]), 32'd1);

    // Phase 3: restart from HALT, redirect to 1 while pc=4 with a valid word
    @(posedge clk); #1;
    redirect = 1'b1;
    redirect_pc = 8'd0;
    sb.delete();
    push_range(0, 6);
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("p3_halt_clr", 32'(halted), 32'd0);
    wait_addr_valid("p3_reach_pc4", 8'd4, 1'b0);
    redirect = 1'b1;
    redirect_pc = 8'd1;
    sb.delete();
    push_range(1, 6);
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("p3_flush", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    chk("p3_first_valid", 32'(instr_valid), 32'd1);
    chk("p3_first_pc", 32'(instr_pc), 32'd1);
    chk("p3_first_instr", instr, 32'h2002_0009);
    drain("p3_drain", 40);

    // Phase 4: async reset mid-stall, then a clean run from RESET_PC
    @(posedge clk); #1;
    instr_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 8'd3;
    sb.delete();
    @(posedge clk); #1;
    redirect = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("p4_stalled", 32'(instr_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("p4_async_valid", 32'(instr_valid), 32'd0);
    chk("p4_async_addr", 32'(imem_addr), 32'd0);
    chk("p4_async_halted", 32'(halted), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push_range(0, 6);
    instr_ready = 1'b1;
    drain("p4_drain", 40);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
